cart_hdr_scan: RTL and testbench
================================

Name: cart_hdr_scan

Overview:
- Runs after reset and on demand. Reads the cartridge header (0x0134..0x014D) over the cartridge-side memory bus, checks the header checksum, and decodes mapper type, ROM size and RAM size.
- Drives the configuration inputs of the mapper (rom_size, ram_size, mapper select). Holds the CPU and mapper in reset until the configuration is valid.
- Owns the cartridge bus while scanning. Afterwards it passes the CPU bus through unchanged.

Parameters:
- RD_WAIT, 2, extra cycles an address is held before read data is sampled (0..7).
- HOLD_ON_BAD, 0, if 1, a checksum mismatch or decode error keeps sys_reset asserted after the scan.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- restart  input  1  one-cycle pulse; starts a new header scan
- cpu_adr  input  15  CPU-side address
- cpu_data  input  8  CPU-side write data
- cpu_write  input  1  CPU-side write strobe
- cpu_cs_rom  input  1  CPU-side ROM chip select
- cpu_cs_ram  input  1  CPU-side RAM chip select
- bus_adr  output  15  to mapper iadr
- bus_data  output  8  to mapper data
- bus_write  output  1  to mapper write
- bus_cs_rom  output  1  to mapper ics_rom
- bus_cs_ram  output  1  to mapper ics_ram
- rd_data  input  8  byte read back from the cartridge ROM
- sys_reset  output  1  reset to CPU and mapper
- cfg_valid  output  1  configuration outputs are valid
- rom_size  output  3  decoded header byte 0x148
- ram_size  output  2  decoded header byte 0x149
- mbc_sel  output  2  0 = ROM only, 1 = MBC1, 2/3 reserved
- cksum_ok  output  1  header checksum matched
- hdr_err  output  1  unsupported type or size byte

Behaviour:
- Reset and polarity:
  - clk is the only clock. reset is synchronous and active-high.
  - While reset is high: sys_reset=1, cfg_valid=0, rom_size=0, ram_size=0, mbc_sel=0, cksum_ok=0, hdr_err=0.
  - While reset is high, state is SCAN with ptr=0x134, wait count 0 and checksum accumulator 0.
- States: SCAN, DONE.
- SCAN bus drive:
  - bus_adr = ptr, bus_cs_rom=1, bus_cs_ram=0, bus_write=0, bus_data=0.
  - sys_reset=1 and cfg_valid=0.
- SCAN byte timing:
  - Each byte holds ptr for RD_WAIT+1 cycles. rd_data is sampled on the clock edge ending the last of those cycles.
  - ptr then increments, so there are no idle cycles between bytes.
- Checksum: for ptr 0x134..0x14C, acc <= acc - rd_data - 1, modulo 256.
- Header captures:
  - ptr 0x147: mapper decode. 0x00, 0x08 or 0x09 -> 0. 0x01..0x03 -> 1. Anything else -> 0 and sets the error flag.
  - ptr 0x148: values 0..6 pass through. Values greater than 6 -> 6 and set the error flag.
  - ptr 0x149: values 0..3 pass through. Values greater than 3 -> 3 and set the error flag.
- ptr 0x14D (final byte):
  - cksum_ok <= (acc == rd_data).
  - All captured values are committed to the outputs in that same edge.
  - The state moves to DONE.
- Scan length: 26 bytes, so exactly 26*(RD_WAIT+1) cycles counted from the first cycle with reset low. Outputs are stable before cfg_valid rises.
- DONE:
  - cfg_valid=1.
  - sys_reset = HOLD_ON_BAD & (!cksum_ok | hdr_err); otherwise 0.
  - bus_* outputs follow the corresponding cpu_* inputs combinationally, with zero latency.
- restart in DONE:
  - Next cycle is SCAN: sys_reset=1, cfg_valid=0, ptr=0x134, acc=0.
  - Configuration outputs keep their old values until the new commit.
- restart in SCAN: the scan restarts from 0x134 on the next cycle, with acc and error flags cleared.
- Priority: reset has priority over restart.
- Config outputs change only at commit or at reset.
- CPU side: cpu_* inputs are ignored during SCAN. The CPU is held in reset and nothing is buffered.

Test Plan:
- Good MBC1 header, RD_WAIT=2:
  - Stimulus: header bytes 0 except 0x147=0x03, 0x148=0x04, 0x149=0x03, 0x14D=0xDD.
  - Required response: cfg_valid rises exactly 78 cycles after reset falls, with mbc_sel=1, rom_size=4, ram_size=3, cksum_ok=1, hdr_err=0, sys_reset=0.
- Bad checksum:
  - Stimulus: same header with 0x14D=0x00.
  - Required response with HOLD_ON_BAD=0: cksum_ok=0 and sys_reset=0.
  - Required response with HOLD_ON_BAD=1: sys_reset stays 1 while cfg_valid=1.
- Unsupported values:
  - Stimulus: 0x147=0x1B, 0x148=0x09 and a correct checksum.
  - Required response: mbc_sel=0, rom_size=6, hdr_err=1, cksum_ok=1.
- Restart mid-scan:
  - Stimulus: pulse restart while ptr=0x140.
  - Required response: bus_adr returns to 0x134 next cycle and cfg_valid rises 78 cycles after the pulse. The same check applies with reset asserted mid-scan.
- Pass-through in DONE:
  - Stimulus: cpu_adr=0x2000, cpu_data=0x05, cpu_write=1, cpu_cs_rom=1.
  - Required response: bus_* equal these values in the same cycle.
- Restart from DONE:
  - Required response: sys_reset=1 and cfg_valid=0 the next cycle; old rom_size is held until the new commit.

Source files
------------

// File: rtl/cart_hdr_scan.sv
// Cartridge header scanner: reads 0x0134..0x014D, verifies the header checksum, decodes the
// mapper/ROM/RAM configuration, and holds the system in reset until the configuration is valid.
module cart_hdr_scan #(
  parameter int unsigned RD_WAIT     = 2,
  parameter bit          HOLD_ON_BAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic [14:0] cpu_adr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_write,
  input  logic        cpu_cs_rom,
  input  logic        cpu_cs_ram,
  output logic [14:0] bus_adr,
  output logic [7:0]  bus_data,
  output logic        bus_write,
  output logic        bus_cs_rom,
  output logic        bus_cs_ram,
  input  logic [7:0]  rd_data,
  output logic        sys_reset,
  output logic        cfg_valid,
  output logic [2:0]  rom_size,
  output logic [1:0]  ram_size,
  output logic [1:0]  mbc_sel,
  output logic        cksum_ok,
  output logic        hdr_err
);

  typedef enum logic [0:0] {StScan, StDone} state_e;

  localparam logic [2:0]  WaitLast = 3'(RD_WAIT);
  localparam logic [14:0] PtrFirst = 15'h0134;
  localparam logic [14:0] PtrMbc   = 15'h0147;
  localparam logic [14:0] PtrRom   = 15'h0148;
  localparam logic [14:0] PtrRam   = 15'h0149;
  localparam logic [14:0] PtrLast  = 15'h014D;

  state_e      state_q, state_d;
  logic [14:0] ptr_q, ptr_d;
  logic [2:0]  wait_q, wait_d;
  logic [7:0]  acc_q, acc_d;
  // Pending captures; only copied to the outputs when the final byte is read.
  logic [1:0]  mbc_q, mbc_d;
  logic [2:0]  rom_q, rom_d;
  logic [1:0]  ram_q, ram_d;
  logic        err_q, err_d;
  logic [2:0]  rom_size_q, rom_size_d;
  logic [1:0]  ram_size_q, ram_size_d;
  logic [1:0]  mbc_sel_q, mbc_sel_d;
  logic        cksum_ok_q, cksum_ok_d;
  logic        hdr_err_q, hdr_err_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wait_d     = wait_q;
    acc_d      = acc_q;
    mbc_d      = mbc_q;
    rom_d      = rom_q;
    ram_d      = ram_q;
    err_d      = err_q;
    rom_size_d = rom_size_q;
    ram_size_d = ram_size_q;
    mbc_sel_d  = mbc_sel_q;
    cksum_ok_d = cksum_ok_q;
    hdr_err_d  = hdr_err_q;

    if (restart) begin
      state_d = StScan;
      ptr_d   = PtrFirst;
      wait_d  = 3'd0;
      acc_d   = 8'd0;
      mbc_d   = 2'd0;
      rom_d   = 3'd0;
      ram_d   = 2'd0;
      err_d   = 1'b0;
    end else if (state_q == StScan) begin
      if (wait_q != WaitLast) begin
        wait_d = wait_q + 3'd1;
      end else begin
        wait_d = 3'd0;
        ptr_d  = ptr_q + 15'd1;
        if (ptr_q == PtrLast) begin
          state_d    = StDone;
          cksum_ok_d = (acc_q == rd_data);
          rom_size_d = rom_q;
          ram_size_d = ram_q;
          mbc_sel_d  = mbc_q;
          hdr_err_d  = err_q;
        end else begin
          acc_d = acc_q - rd_data - 8'd1;
          case (ptr_q)
            PtrMbc: begin
              case (rd_data)
                8'h00, 8'h08, 8'h09: mbc_d = 2'd0;
                8'h01, 8'h02, 8'h03: mbc_d = 2'd1;
                default: begin
                  mbc_d = 2'd0;
                  err_d = 1'b1;
                end
              endcase
            end
            PtrRom: begin
              if (rd_data > 8'd6) begin
                rom_d = 3'd6;
                err_d = 1'b1;
              end else begin
                rom_d = rd_data[2:0];
              end
            end
            PtrRam: begin
              if (rd_data > 8'd3) begin
                ram_d = 2'd3;
                err_d = 1'b1;
              end else begin
                ram_d = rd_data[1:0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    if (state_q == StScan) begin
      bus_adr    = ptr_q;
      bus_data   = 8'd0;
      bus_write  = 1'b0;
      bus_cs_rom = 1'b1;
      bus_cs_ram = 1'b0;
      sys_reset  = 1'b1;
      cfg_valid  = 1'b0;
    end else begin
      bus_adr    = cpu_adr;
      bus_data   = cpu_data;
      bus_write  = cpu_write;
      bus_cs_rom = cpu_cs_rom;
      bus_cs_ram = cpu_cs_ram;
      sys_reset  = HOLD_ON_BAD & (~cksum_ok_q | hdr_err_q);
      cfg_valid  = 1'b1;
    end
  end

  assign rom_size = rom_size_q;
  assign ram_size = ram_size_q;
  assign mbc_sel  = mbc_sel_q;
  assign cksum_ok = cksum_ok_q;
  assign hdr_err  = hdr_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StScan;
      ptr_q      <= PtrFirst;
      wait_q     <= 3'd0;
      acc_q      <= 8'd0;
      mbc_q      <= 2'd0;
      rom_q      <= 3'd0;
      ram_q      <= 2'd0;
      err_q      <= 1'b0;
      rom_size_q <= 3'd0;
      ram_size_q <= 2'd0;
      mbc_sel_q  <= 2'd0;
      cksum_ok_q <= 1'b0;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
      acc_q      <= acc_d;
      mbc_q      <= mbc_d;
      rom_q      <= rom_d;
      ram_q      <= ram_d;
      err_q      <= err_d;
      rom_size_q <= rom_size_d;
      ram_size_q <= ram_size_d;
      mbc_sel_q  <= mbc_sel_d;
      cksum_ok_q <= cksum_ok_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

endmodule

// File: tb/tb_cart_hdr_scan.sv
// Scoreboard bench for cart_hdr_scan: two instances (HOLD_ON_BAD 0 and 1) read the same header
// model; a monitor checks each commit against a reference decode of the header bytes.
module tb_cart_hdr_scan;

  localparam int unsigned RdWait     = 2;
  localparam int          ScanCycles = 26 * (RdWait + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, restart;
  logic [14:0] cpu_adr;
  logic [7:0]  cpu_data;
  logic        cpu_write, cpu_cs_rom, cpu_cs_ram;

  logic [14:0] bus_adr0, bus_adr1;
  logic [7:0]  bus_data0, bus_data1, rd_data0, rd_data1;
  logic        bus_write0, bus_write1, bus_cs_rom0, bus_cs_rom1, bus_cs_ram0, bus_cs_ram1;
  logic        sys_reset0, sys_reset1, cfg_valid0, cfg_valid1;
  logic [2:0]  rom_size0, rom_size1;
  logic [1:0]  ram_size0, ram_size1, mbc_sel0, mbc_sel1;
  logic        cksum_ok0, cksum_ok1, hdr_err0, hdr_err1;

  cart_hdr_scan #(.RD_WAIT(RdWait), .HOLD_ON_BAD(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .restart(restart),
    .cpu_adr(cpu_adr), .cpu_data(cpu_data), .cpu_write(cpu_write),
    .cpu_cs_rom(cpu_cs_rom), .cpu_cs_ram(cpu_cs_ram),
    .bus_adr(bus_adr0), .bus_data(bus_data0), .bus_write(bus_write0),
    .bus_cs_rom(bus_cs_rom0), .bus_cs_ram(bus_cs_ram0), .rd_data(rd_data0),
    .sys_reset(sys_reset0), .cfg_valid(cfg_valid0), .rom_size(rom_size0),
    .ram_size(ram_size0), .mbc_sel(mbc_sel0), .cksum_ok(cksum_ok0), .hdr_err(hdr_err0)
  );

  cart_hdr_scan #(.RD_WAIT(RdWait), .HOLD_ON_BAD(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .restart(restart),
    .cpu_adr(cpu_adr), .cpu_data(cpu_data), .cpu_write(cpu_write),
    .cpu_cs_rom(cpu_cs_rom), .cpu_cs_ram(cpu_cs_ram),
    .bus_adr(bus_adr1), .bus_data(bus_data1), .bus_write(bus_write1),
    .bus_cs_rom(bus_cs_rom1), .bus_cs_ram(bus_cs_ram1), .rd_data(rd_data1),
    .sys_reset(sys_reset1), .cfg_valid(cfg_valid1), .rom_size(rom_size1),
    .ram_size(ram_size1), .mbc_sel(mbc_sel1), .cksum_ok(cksum_ok1), .hdr_err(hdr_err1)
  );

  // Header bytes 0x134..0x14D; everything else in the ROM reads 0xFF.
  logic [7:0] hdr [26];

  always_comb begin
    rd_data0 = 8'hFF;
    if (bus_adr0 >= 15'h134 && bus_adr0 <= 15'h14D) rd_data0 = hdr[5'(bus_adr0 - 15'h134)];
  end
  always_comb begin
    rd_data1 = 8'hFF;
    if (bus_adr1 >= 15'h134 && bus_adr1 <= 15'h14D) rd_data1 = hdr[5'(bus_adr1 - 15'h134)];
  end

  typedef struct {
    int mbc;
    int rom;
    int ram;
    int ck;
    int err;
    int hold;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decode straight from the header layout.
  function automatic exp_t ref_model();
    exp_t r;
    int   sum = 0;
    int   b;
    for (int i = 0; i < 25; i++) sum += int'(hdr[i]) + 1;
    r.ck  = (((25600 - sum) % 256) == int'(hdr[25])) ? 1 : 0;
    r.err = 0;
    b = int'(hdr[19]);
    if (b == 0 || b == 8 || b == 9) r.mbc = 0;
    else if (b >= 1 && b <= 3) r.mbc = 1;
    else begin r.mbc = 0; r.err = 1; end
    b = int'(hdr[20]);
    if (b > 6) begin r.rom = 6; r.err = 1; end else r.rom = b;
    b = int'(hdr[21]);
    if (b > 3) begin r.ram = 3; r.err = 1; end else r.ram = b;
    r.hold = (r.ck == 0 || r.err == 1) ? 1 : 0;
    return r;
  endfunction

  task automatic fix_checksum();
    int sum = 0;
    for (int i = 0; i < 25; i++) sum += int'(hdr[i]) + 1;
    hdr[25] = 8'((25600 - sum) % 256);
  endtask

  task automatic load_hdr(input logic [7:0] mbc, input logic [7:0] rom, input logic [7:0] ram);
    for (int i = 0; i < 26; i++) hdr[i] = 8'h00;
    hdr[19] = mbc;
    hdr[20] = rom;
    hdr[21] = ram;
  endtask

  task automatic start_by_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic start_by_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    start_cyc = cyc;
  endtask

  // Waits for cfg_valid while scrambling the CPU side; the scan bus must stay a plain ROM read.
  task automatic wait_done(input string name);
    bit found = 1'b0;
    bit bus_bad = 1'b0;
    for (int i = 0; i < ScanCycles + 20; i++) begin
      @(negedge clk);
      if (cfg_valid0) begin
        found = 1'b1;
        break;
      end
      if (bus_write0 || bus_cs_ram0 || !bus_cs_rom0 || bus_data0 != 8'h00 || !sys_reset0)
        bus_bad = 1'b1;
      cpu_adr    = 15'($urandom);
      cpu_data   = 8'($urandom);
      cpu_write  = 1'($urandom);
      cpu_cs_rom = 1'($urandom);
      cpu_cs_ram = 1'($urandom);
    end
    check({name, "_done"}, int'(found), 1);
    check({name, "_scan_bus"}, int'(bus_bad), 0);
  endtask

  always @(negedge clk) begin
    if (cfg_valid0 && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc - start_cyc, ScanCycles);
        check("mbc_sel", int'(mbc_sel0), mon_e.mbc);
        check("rom_size", int'(rom_size0), mon_e.rom);
        check("ram_size", int'(ram_size0), mon_e.ram);
        check("cksum_ok", int'(cksum_ok0), mon_e.ck);
        check("hdr_err", int'(hdr_err0), mon_e.err);
        check("sys_reset_hold0", int'(sys_reset0), 0);
        check("sys_reset_hold1", int'(sys_reset1), mon_e.hold);
        check("cfg_valid_hold1", int'(cfg_valid1), 1);
      end
    end
    prev_valid <= cfg_valid0;
  end

  initial begin
    reset = 1'b1; restart = 1'b0;
    cpu_adr = '0; cpu_data = '0; cpu_write = 1'b0; cpu_cs_rom = 1'b0; cpu_cs_ram = 1'b0;
    load_hdr(8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sys_reset", int'(sys_reset0), 1);
    check("rst_cfg_valid", int'(cfg_valid0), 0);
    check("rst_cfg", int'({rom_size0, ram_size0, mbc_sel0, cksum_ok0, hdr_err0}), 0);
    check("rst_bus_adr", int'(bus_adr0), 'h134);
    check("rst_bus_cs_rom", int'(bus_cs_rom0), 1);

    // Good MBC1 header with the literal checksum.
    load_hdr(8'h03, 8'h04, 8'h03);
    hdr[25] = 8'hDD;
    exp_q.push_back(ref_model());
    @(posedge clk); #1 reset = 1'b0;
    start_cyc = cyc;
    wait_done("good");
    check("good_cksum", int'(cksum_ok0), 1);
    check("good_rom", int'(rom_size0), 4);

    // CPU pass-through in DONE, same cycle.
    @(posedge clk); #1;
    cpu_adr = 15'h2000; cpu_data = 8'h05; cpu_write = 1'b1; cpu_cs_rom = 1'b1; cpu_cs_ram = 1'b0;
    #1;
    check("pt_adr", int'(bus_adr0), 'h2000);
    check("pt_data", int'(bus_data0), 5);
    check("pt_wr_cs", int'({bus_write0, bus_cs_rom0, bus_cs_ram0}), 3'b110);
    cpu_adr = 15'h5A5A; cpu_cs_ram = 1'b1; cpu_write = 1'b0;
    #1;
    check("pt_adr2", int'(bus_adr0), 'h5A5A);
    check("pt_ram2", int'({bus_write0, bus_cs_ram0}), 2'b01);

    // Bad checksum, started by reset.
    hdr[25] = 8'h00;
    exp_q.push_back(ref_model());
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_clears_rom", int'(rom_size0), 0);
    reset = 1'b0;
    start_cyc = cyc;
    wait_done("badck");
    check("badck_ok", int'(cksum_ok0), 0);
    check("badck_hold1", int'(sys_reset1 & cfg_valid1), 1);

    // Unsupported values, started by restart from DONE; old rom_size 4 held until commit.
    load_hdr(8'h1B, 8'h09, 8'h00);
    fix_checksum();
    check("unsup_cksum_byte", int'(hdr[25]), 'hC3);
    exp_q.push_back(ref_model());
    start_by_restart();
    check("rs_done_sys_reset", int'(sys_reset0), 1);
    check("rs_done_cfg_valid", int'(cfg_valid0), 0);
    check("rs_done_rom_held", int'(rom_size0), 4);
    repeat (40) @(posedge clk);
    #1 check("rs_mid_rom_held", int'(rom_size0), 4);
    wait_done("unsup");
    check("unsup_mbc", int'(mbc_sel0), 0);
    check("unsup_rom", int'(rom_size0), 6);
    check("unsup_err", int'(hdr_err0), 1);

    // Restart and reset at ptr 0x140.
    for (int mode = 0; mode < 2; mode++) begin
      bit seen = 1'b0;
      load_hdr(8'h01, 8'h02, 8'h01);
      fix_checksum();
      exp_q.push_back(ref_model());
      start_by_restart();
      for (int i = 0; i < ScanCycles; i++) begin
        @(posedge clk); #1;
        if (bus_adr0 == 15'h140) begin
          seen = 1'b1;
          break;
        end
      end
      check("mid_reach_140", int'(seen), 1);
      if (mode == 0) restart = 1'b1;
      else reset = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      reset = 1'b0;
      start_cyc = cyc;
      check(mode == 0 ? "mid_restart_adr" : "mid_reset_adr", int'(bus_adr0), 'h134);
      check("mid_sys_reset", int'(sys_reset0), 1);
      wait_done(mode == 0 ? "mid_restart" : "mid_reset");
    end

    // Randomized headers.
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 26; i++) hdr[i] = 8'($urandom);
      case ($urandom_range(0, 7))
        0: hdr[19] = 8'h00;
        1: hdr[19] = 8'h01;
        2: hdr[19] = 8'h02;
        3: hdr[19] = 8'h03;
        4: hdr[19] = 8'h08;
        5: hdr[19] = 8'h09;
        default: ;
      endcase
      hdr[20] = 8'($urandom_range(0, 9));
      hdr[21] = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 3) != 0) fix_checksum();
      exp_q.push_back(ref_model());
      if ($urandom_range(0, 1) == 0) start_by_restart();
      else start_by_reset();
      wait_done("rand");
    end

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
